// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle 16x16 multiply / 16/16 divide sequencer driving the shared ALU
module alu_muldiv_seq #(
    parameter int WIDTH     = 16,
    parameter int ITER_BITS = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero,
    output logic             alu_own,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    output logic             alu_is_compare,
    input  logic [WIDTH-1:0] alu_s
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [3:0]           SEL_ADD = 4'b0100;
    localparam logic [3:0]           SEL_SUB = 4'b0101;
    localparam logic [ITER_BITS-1:0] LAST    = ITER_BITS'(WIDTH);
    state_t               state_q, state_d;
    logic [ITER_BITS-1:0] cnt_q, cnt_d;
    logic                 op_q, op_d;
    logic [WIDTH-1:0]     h_q, h_d, l_q, l_d, m_q, m_d;
    logic [WIDTH-1:0]     res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic                 dbz_q, dbz_d;
    logic [WIDTH-1:0]     rs, t;
    logic                 take, c;
    // H/L/M hold the partial product, multiplier and multiplicand for MUL,
    // and the remainder, quotient and divisor for DIV
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= 1'b0;
            h_q      <= '0;
            l_q      <= '0;
            m_q      <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            h_q      <= h_d;
            l_q      <= l_d;
            m_q      <= m_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dbz_q    <= dbz_d;
        end
    end
    // next state, one ALU op per RUN cycle, results captured on the final step
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        h_d      = h_q;
        l_d      = l_q;
        m_d      = m_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dbz_d    = dbz_q;
        alu_a    = '0;
        alu_b    = '0;
        alu_sel  = '0;
        rs       = {h_q[WIDTH-2:0], l_q[WIDTH-1]};
        take     = h_q[WIDTH-1] | (rs >= m_q);
        c        = l_q[0] & (alu_s < h_q);
        t        = l_q[0] ? alu_s : h_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d  = op;
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    if (op && opb == '0) begin
                        state_d  = DONE;
                        res_hi_d = opa;
                        res_lo_d = '1;
                        dbz_d    = 1'b1;
                    end else begin
                        state_d = RUN;
                        h_d     = '0;
                        l_d     = op ? opa : opb;
                        m_d     = op ? opb : opa;
                    end
                end
            end
            RUN: begin
                alu_a   = op_q ? rs : h_q;
                alu_b   = m_q;
                alu_sel = op_q ? SEL_SUB : SEL_ADD;
                h_d     = op_q ? (take ? alu_s : rs) : {c, t[WIDTH-1:1]};
                l_d     = op_q ? {l_q[WIDTH-2:0], take} : {t[0], l_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_d == LAST) begin
                    state_d  = DONE;
                    res_hi_d = h_d;
                    res_lo_d = l_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign busy           = state_q != IDLE;
    assign done           = state_q == DONE;
    assign alu_own        = state_q == RUN;
    assign alu_is_compare = 1'b0;
    assign result_hi      = res_hi_q;
    assign result_lo      = res_lo_q;
    assign div_by_zero    = dbz_q;
endmodule
